// File: rtl/vga_timing.sv
// Free-running raster timing generator: pixel/line counters plus registered
// sync, blanking, base colour and end-of-frame flags with zero count-to-flag skew.
module vga_timing #(
  parameter int          H_ACTIVE = 1920,
  parameter int          H_FP     = 88,
  parameter int          H_SYNC   = 44,
  parameter int          H_BP     = 148,
  parameter int          V_ACTIVE = 1080,
  parameter int          V_FP     = 4,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 36,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblnk,
  output logic        o_vblnk,
  output logic [11:0] o_rgb,
  output logic        o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0) begin : g_bad_h_zero
    $error("vga_timing: horizontal active/porch/sync values must be non-zero");
  end
  if (V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_v_zero
    $error("vga_timing: vertical active/porch/sync values must be non-zero");
  end
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  // Region boundaries as 12-bit constants so every compare is plain 12-bit unsigned.
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_BLANK_BEG  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_BLANK_BEG  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_next;
  logic [11:0] v_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        hblnk_next;
  logic        vblnk_next;
  logic [11:0] rgb_next;
  logic        frame_end_next;

  always_comb begin
    h_next = o_hcount + 12'd1;
    v_next = o_vcount;
    if (o_hcount == H_LAST) begin
      h_next = 12'd0;
      if (o_vcount == V_LAST) begin
        v_next = 12'd0;
      end else begin
        v_next = o_vcount + 12'd1;
      end
    end
  end

  // Flags decode the next position so they land in the same cycle as the counts.
  always_comb begin
    hblnk_next     = (h_next >= H_BLANK_BEG);
    vblnk_next     = (v_next >= V_BLANK_BEG);
    hsync_next     = ((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vsync_next     = ((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END)) ? VS_POL : ~VS_POL;
    rgb_next       = (hblnk_next || vblnk_next) ? 12'h000 : BG_RGB;
    frame_end_next = (h_next == H_LAST) && (v_next == V_LAST);
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      o_hcount    <= 12'd0;
      o_vcount    <= 12'd0;
      o_hsync     <= ~HS_POL;
      o_vsync     <= ~VS_POL;
      o_hblnk     <= 1'b0;
      o_vblnk     <= 1'b0;
      o_rgb       <= BG_RGB;
      o_frame_end <= 1'b0;
    end else if (i_en) begin
      o_hcount    <= h_next;
      o_vcount    <= v_next;
      o_hsync     <= hsync_next;
      o_vsync     <= vsync_next;
      o_hblnk     <= hblnk_next;
      o_vblnk     <= vblnk_next;
      o_rgb       <= rgb_next;
      o_frame_end <= frame_end_next;
    end
  end

endmodule
